pwm_channel_shadow: RTL

Per-channel PWM setting store between the I2C write stream and `pwm_driver`. It snoops the register-write bus that `i2c_target` drives into `register_data`, and decodes the PCA9685 LEDn and ALL_LED byte registers into 16 channels of on/off flags and 12-bit high/low values. New settings commit to the outputs only at a PWM period boundary, so the LED outputs never see a torn or half-written setting.

---
 rtl/pca9685_regs_pkg.sv | 40 ++++
 rtl/pwm_channel_regs.sv | 69 ++++++
 rtl/pwm_channel_shadow.sv | 105 ++++++++++
 3 files changed

// File: rtl/pca9685_regs_pkg.sv
// ---------------------------------------------------------------------------
// pca9685_regs_pkg
// Shared register-map constants and the per-channel PWM setting type used by
// the PCA9685-style PWM channel store and its channel register slices.
//
// Contents:
//   LED0_ON_L_ADDR     first LEDn byte register (channel 0 ON_L)
//   LED_LAST_ADDR      last LEDn byte register (channel 15 OFF_H)
//   ALL_LED_ON_L_ADDR  first ALL_LED broadcast register
//   ALL_LED_OFF_H_ADDR last ALL_LED broadcast register
//   FULL_FLAG_BIT      bit position of the full-on / full-off flag in *_H
//   pwm_ch_t           {on, off, high[11:0], low[11:0]} for one channel
//   pwm_field_e        byte field selected by the low address offset
// ---------------------------------------------------------------------------
package pca9685_regs_pkg;

    localparam logic [7:0] LED0_ON_L_ADDR     = 8'h06;
    localparam logic [7:0] LED_LAST_ADDR      = 8'h45;
    localparam logic [7:0] ALL_LED_ON_L_ADDR  = 8'hFA;
    localparam logic [7:0] ALL_LED_OFF_H_ADDR = 8'hFD;
    localparam int         FULL_FLAG_BIT      = 4;

    typedef struct packed {
        logic        on;
        logic        off;
        logic [11:0] high;
        logic [11:0] low;
    } pwm_ch_t;

    typedef enum logic [1:0] {
        FIELD_ON_L  = 2'd0,
        FIELD_ON_H  = 2'd1,
        FIELD_OFF_L = 2'd2,
        FIELD_OFF_H = 2'd3
    } pwm_field_e;

    // Reset value of a channel: full-off, counts cleared.
    localparam pwm_ch_t PWM_CH_RESET = '{on: 1'b0, off: 1'b1, high: 12'h000, low: 12'h000};

endpackage

// File: rtl/pwm_channel_regs.sv
// ---------------------------------------------------------------------------
// pwm_channel_regs
// One PWM channel's setting store: a staging copy written byte-by-byte from
// the register bus and, when PWM_SHADOW_EN is defined, an active copy that
// loads from staging on commit. Without PWM_SHADOW_EN the staging copy drives
// the output directly and commit_i is ignored.
//
// Ports:
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   field_we_i  one-hot byte field write enable (bit = pwm_field_e)
//   byte_i      byte being written
//   commit_i    load active copy from staging (shadow build only)
//   ch_o        setting presented to the PWM driver
//
// Configuration macro: PWM_SHADOW_EN
// ---------------------------------------------------------------------------
module pwm_channel_regs
    import pca9685_regs_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] field_we_i,
    input  logic [7:0] byte_i,
    input  logic       commit_i,
    output pwm_ch_t    ch_o
);

    pwm_ch_t stage_q, stage_d;

    // Merge the written byte into the staging copy; only one field is
    // selected at a time and bits [7:5] of the *_H bytes are dropped.
    always_comb begin
        stage_d = stage_q;
        if (field_we_i[FIELD_ON_L])  stage_d.high[7:0]  = byte_i;
        if (field_we_i[FIELD_ON_H])  begin
            stage_d.high[11:8] = byte_i[3:0];
            stage_d.on         = byte_i[FULL_FLAG_BIT];
        end
        if (field_we_i[FIELD_OFF_L]) stage_d.low[7:0]   = byte_i;
        if (field_we_i[FIELD_OFF_H]) begin
            stage_d.low[11:8]  = byte_i[3:0];
            stage_d.off        = byte_i[FULL_FLAG_BIT];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) stage_q <= PWM_CH_RESET;
        else         stage_q <= stage_d;
    end

`ifdef PWM_SHADOW_EN
    pwm_ch_t active_q;

    // The commit samples the pre-write staging value, so a write landing in
    // the commit cycle waits for the following period boundary.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       active_q <= PWM_CH_RESET;
        else if (commit_i) active_q <= stage_q;
    end

    assign ch_o = active_q;
`else
    logic unused_commit;
    assign unused_commit = commit_i;
    assign ch_o          = stage_q;
`endif

endmodule

// File: rtl/pwm_channel_shadow.sv
// ---------------------------------------------------------------------------
// pwm_channel_shadow
// Per-channel PWM setting store between the I2C register-write stream and the
// PWM driver. Decodes LEDn (0x06-0x45) and ALL_LED (0xFA-0xFD) byte writes
// into 16 channels of on/off flags and 12-bit high/low counts. With
// PWM_SHADOW_EN defined, new settings reach the outputs only when the PWM
// counter wraps to zero; otherwise they appear the cycle after the write.
//
// Ports:
//   clk_i                   system clock
//   rst_ni                  asynchronous active-low reset
//   write_register_id_i     register address being written
//   write_register_value_i  byte being written
//   write_enable_i          one-cycle write strobe
//   counter_i               prescaled PWM counter
//   pwm_on_o / pwm_off_o    full-on / full-off flag per channel
//   pwm_high_o / pwm_low_o  ON / OFF count, channel n in bits [12n+11:12n]
//   commit_o                one-cycle pulse when outputs take new settings
//
// Configuration macro: PWM_SHADOW_EN
// ---------------------------------------------------------------------------
module pwm_channel_shadow
    import pca9685_regs_pkg::*;
#(
    parameter int NUM_CH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [7:0]           write_register_id_i,
    input  logic [7:0]           write_register_value_i,
    input  logic                 write_enable_i,
    input  logic [11:0]          counter_i,
    output logic [NUM_CH-1:0]    pwm_on_o,
    output logic [NUM_CH-1:0]    pwm_off_o,
    output logic [12*NUM_CH-1:0] pwm_high_o,
    output logic [12*NUM_CH-1:0] pwm_low_o,
    output logic                 commit_o
);

    logic       led_hit;
    logic       all_hit;
    logic [3:0] ch_idx;
    logic [1:0] field;
    logic [3:0] field_onehot;
    logic       commit_d;
    logic       commit_q;

    // Channel bases sit at 2 mod 4, as does the ALL_LED base, so the field
    // offset is addr[1:0] - 2 for both the per-channel and broadcast ranges.
    assign led_hit      = (write_register_id_i >= LED0_ON_L_ADDR) &&
                          (write_register_id_i <= LED_LAST_ADDR);
    assign all_hit      = (write_register_id_i >= ALL_LED_ON_L_ADDR) &&
                          (write_register_id_i <= ALL_LED_OFF_H_ADDR);
    assign ch_idx       = 4'((write_register_id_i - LED0_ON_L_ADDR) >> 2);
    assign field        = write_register_id_i[1:0] - 2'd2;
    assign field_onehot = 4'b0001 << field;

`ifdef PWM_SHADOW_EN
    logic [11:0] prev_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) prev_cnt_q <= '0;
        else         prev_cnt_q <= counter_i;
    end

    // Any nonzero-to-zero transition is a period boundary, including a
    // prescaler reset that wraps early; a counter parked at 0 never commits.
    assign commit_d = (counter_i == 12'd0) && (prev_cnt_q != 12'd0);
`else
    logic unused_counter;
    assign unused_counter = ^counter_i;
    assign commit_d       = write_enable_i && (led_hit || all_hit);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) commit_q <= 1'b0;
        else         commit_q <= commit_d;
    end

    assign commit_o = commit_q;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        localparam logic [3:0] CH_IDX = 4'(n);
        logic [3:0] field_we;
        pwm_ch_t    ch;

        assign field_we = (write_enable_i && (all_hit || (led_hit && ch_idx == CH_IDX)))
                          ? field_onehot : 4'b0000;

        pwm_channel_regs u_regs (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .field_we_i (field_we),
            .byte_i     (write_register_value_i),
            .commit_i   (commit_d),
            .ch_o       (ch)
        );

        assign pwm_on_o[n]            = ch.on;
        assign pwm_off_o[n]           = ch.off;
        assign pwm_high_o[12*n +: 12] = ch.high;
        assign pwm_low_o[12*n +: 12]  = ch.low;
    end

endmodule
